// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// One memory request channel: requester-driven enables, address and write data,
// plus memory-driven completion strobes and read data.
//   master : the side that issues requests (a host port, or the arbiter
//            facing the BlockRam)
//   slave  : the side that serves requests (the arbiter facing a host port,
//            or the BlockRam)
// Signals: read_enable, write_enable, addr[ADDR_WIDTH], write_data[DATA_WIDTH]
//          (master -> slave); read_ready, write_ready, read_data[DATA_WIDTH]
//          (slave -> master).
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  read_enable;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_ready;
    logic                  write_ready;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output read_enable, write_enable, addr, write_data,
        input  read_ready, write_ready, read_data
    );

    modport slave (
        input  read_enable, write_enable, addr, write_data,
        output read_ready, write_ready, read_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port round-robin arbiter in front of a single BlockRam port. Port 0 is
// the host, port 1 the Dijkstra engine. The owner's request is forwarded
// combinationally to the memory and the memory's completion strobes and read
// data are routed back to the owner only.
//
// Ports:
//   clock          single clock, rising edge
//   reset          asynchronous, active-high
//   p0  (slave)    host request channel
//   p1  (slave)    engine request channel
//   mem (master)   BlockRam channel
//   timeout_error  sticky grant-watchdog flag (0 when the watchdog is absent)
//   grant[1:0]     one-hot owner: 01 = port 0, 10 = port 1, 00 = none
//
// Build option: define MEM_ARBITER_TIMEOUT_EN to add the grant watchdog. An
// owner still holding an enable after TIMEOUT_CYCLES grant cycles loses the
// grant, raises timeout_error and is masked until it drops both enables.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MADDR_WIDTH    = 32,
    parameter int MDATA_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_arbiter_if.slave         p0,
    mem_arbiter_if.slave         p1,
    mem_arbiter_if.master        mem,
    output logic                 timeout_error,
    output logic [1:0]           grant
);

    // State codes double as the one-hot grant vector.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_GRANT0 = 2'b01;
    localparam logic [1:0] ST_GRANT1 = 2'b10;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;

    // Raw "holding an enable" per port; drives release and mask clearing.
    logic p0_active, p1_active;
    // Eligible to win arbitration.
    logic p0_req, p1_req;

    assign p0_active = p0.read_enable | p0.write_enable;
    assign p1_active = p1.read_enable | p1.write_enable;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mask0_q, mask0_d;
    logic             mask1_q, mask1_d;
    logic             timeout_q, timeout_d;

    assign p0_req        = p0_active & ~mask0_q;
    assign p1_req        = p1_active & ~mask1_q;
    assign timeout_error = timeout_q;
`else
    assign p0_req        = p0_active;
    assign p1_req        = p1_active;
    assign timeout_error = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        last_grant_d = last_grant_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        // A mask survives only while its port keeps an enable high.
        mask0_d   = mask0_q & p0_active;
        mask1_d   = mask1_q & p1_active;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
                cnt_d = '0;
`endif
                // On a tie, the port that did not win last time goes next.
                if (p0_req && (!p1_req || last_grant_q)) begin
                    state_d      = ST_GRANT0;
                    last_grant_d = 1'b0;
                end else if (p1_req) begin
                    state_d      = ST_GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            ST_GRANT0: begin
                if (!p0_active) begin
                    state_d = ST_IDLE;
`ifdef MEM_ARBITER_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    mask0_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_GRANT1: begin
                if (!p1_active) begin
                    state_d = ST_IDLE;
`ifdef MEM_ARBITER_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    mask1_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;  // port 0 wins the first tie
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            mask0_q   <= 1'b0;
            mask1_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mask0_q   <= mask0_d;
            mask1_q   <= mask1_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Request forwarding: owner's request to the memory, zeros when idle.
    // Write wins when an owner raises both enables.
    // -------------------------------------------------------------------------
    logic                   sel_re, sel_we;
    logic [MADDR_WIDTH-1:0] sel_addr;
    logic [MDATA_WIDTH-1:0] sel_wdata;

    always_comb begin
        sel_re    = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (state_q)
            ST_GRANT0: begin
                sel_we    = p0.write_enable;
                sel_re    = p0.read_enable & ~p0.write_enable;
                sel_addr  = p0.addr;
                sel_wdata = p0.write_data;
            end
            ST_GRANT1: begin
                sel_we    = p1.write_enable;
                sel_re    = p1.read_enable & ~p1.write_enable;
                sel_addr  = p1.addr;
                sel_wdata = p1.write_data;
            end
            default: ;
        endcase
    end

    assign mem.read_enable  = sel_re;
    assign mem.write_enable = sel_we;
    assign mem.addr         = sel_addr;
    assign mem.write_data   = sel_wdata;

    // -------------------------------------------------------------------------
    // Response routing: only the owner sees completions and read data.
    // -------------------------------------------------------------------------
    logic own0, own1;
    assign own0 = (state_q == ST_GRANT0);
    assign own1 = (state_q == ST_GRANT1);

    assign p0.read_ready  = own0 & mem.read_ready;
    assign p0.write_ready = own0 & mem.write_ready;
    assign p0.read_data   = own0 ? mem.read_data : '0;
    assign p1.read_ready  = own1 & mem.read_ready;
    assign p1.write_ready = own1 & mem.write_ready;
    assign p1.read_data   = own1 ? mem.read_data : '0;

    assign grant = state_q;

endmodule
